// File: rtl/i2c_target_mem.sv
// I2C target with a DEPTH-byte register file and an auto-incrementing pointer; 2-flop input sync + 1 edge stage.
// SDA updates one cycle after a detected SCL fall; the target never stretches SCL, so there is no backpressure.
`timescale 1ns/1ps
module i2c_target_mem #(
    parameter logic [6:0] TARGET_ADDR = 7'h22,
    parameter int         DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_drive_low,
    output logic                     busy,
    output logic                     wr_strobe,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [7:0]               wr_data
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] WR_BYTE   = 3'd3;
    localparam logic [2:0] WR_ACK    = 3'd4;
    localparam logic [2:0] RD_BYTE   = 3'd5;
    localparam logic [2:0] RD_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

    logic          scl_s1_q, scl_s2_q, scl_prev_q;
    logic          sda_s1_q, sda_s2_q, sda_prev_q;
    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          first_q, first_d;
    logic          sda_low_q, sda_low_d;
    logic          busy_q, busy_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          mem_we;
    logic [7:0]    mem_q [DEPTH];

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte, rd_byte;

    assign scl_rise  = scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q & scl_prev_q;
    assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
    assign rx_byte   = {shift_q[6:0], sda_s2_q};
    assign rd_byte   = mem_q[ptr_q];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        first_d     = first_q;
        sda_low_d   = sda_low_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_we      = 1'b0;
        if (stop_det) begin
            state_d   = IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            cnt_d     = 4'd0;
            sda_low_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (rx_byte[7:1] == TARGET_ADDR) begin
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                // sda_low_q tells which SCL fall this is: end of bit 8 (start ACK) or end of bit 9.
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_d = 1'b1;
                            busy_d    = 1'b1;
                        end else begin
                            cnt_d = 4'd0;
                            if (shift_q[0]) begin
                                state_d   = RD_BYTE;
                                shift_d   = rd_byte;
                                sda_low_d = ~rd_byte[7];
                            end else begin
                                state_d   = WR_BYTE;
                                first_d   = 1'b1;
                                sda_low_d = 1'b0;
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            state_d = WR_ACK;
                            if (first_q) begin
                                ptr_d   = rx_byte[AW-1:0];
                                first_d = 1'b0;
                            end else begin
                                mem_we      = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = rx_byte;
                                ptr_d       = ptr_q + 1'b1;
                            end
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_d = 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = WR_BYTE;
                            cnt_d     = 4'd0;
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_low_d = 1'b0;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], shift_q[7]};
                            sda_low_d = ~shift_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_s2_q) begin
                        state_d = WAIT_STOP;
                    end else if (scl_fall) begin
                        state_d   = RD_BYTE;
                        cnt_d     = 4'd0;
                        shift_d   = rd_byte;
                        sda_low_d = ~rd_byte[7];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q    <= 1'b1;
            scl_s2_q    <= 1'b1;
            scl_prev_q  <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'd0;
            ptr_q       <= '0;
            first_q     <= 1'b0;
            sda_low_q   <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'd0;
        end else begin
            scl_s1_q    <= scl_i;
            scl_s2_q    <= scl_s1_q;
            scl_prev_q  <= scl_s2_q;
            sda_s1_q    <= sda_i;
            sda_s2_q    <= sda_s1_q;
            sda_prev_q  <= sda_s2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            first_q     <= first_d;
            sda_low_q   <= sda_low_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Register file contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= rx_byte;
        end
    end

    assign sda_drive_low = sda_low_q;
    assign busy          = busy_q;
    assign wr_strobe     = wr_strobe_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: behavioural open-drain I2C master, table of transactions, byte-level scoreboard.
`timescale 1ns/1ps
module tb_i2c_target_mem;
    localparam int Q = 80;

    typedef struct {
        logic [6:0]  addr;
        int          nwr;
        logic [23:0] wb;
        int          nrd;
        logic        exp_ack;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_low;
    logic       sda_bus;
    logic       dut_low;
    logic       busy;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    assign sda_bus = ~(m_low | dut_low);
    always #5 clk = ~clk;

    i2c_target_mem #(.TARGET_ADDR(7'h22), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus),
        .sda_drive_low(dut_low), .busy(busy), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int          checks = 0;
    int          failures = 0;
    logic [11:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  model_mem [16];
    logic [3:0]  model_ptr = 4'd0;
    vec_t        vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wr_strobe) begin
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got addr=%0d data=%0h expected none", wr_addr, wr_data);
            end else begin
                check("wr_strobe_addr_data", {20'd0, wr_addr, wr_data}, {20'd0, wr_q.pop_front()});
            end
        end
    end

    task automatic start_cond();
        m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0;
    endtask

    task automatic stop_cond();
        m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
    endtask

    task automatic write_bit(input logic b);
        m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack_n);
    endtask

    task automatic recv_byte(input logic last, output logic [7:0] d);
        logic bt;
        d = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bt);
            d[i] = bt;
        end
        write_bit(last);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic       a;
        logic [7:0] d;
        logic [7:0] e;
        start_cond();
        send_byte({v.addr, (v.nwr == 0)}, a);
        check($sformatf("v%0d_addr_ack", idx), {31'd0, a}, v.exp_ack ? 32'd0 : 32'd1);
        check($sformatf("v%0d_busy", idx), {31'd0, busy}, {31'd0, v.exp_ack});
        if (v.exp_ack) begin
            for (int i = 0; i < v.nwr; i++) begin
                d = v.wb[8*i +: 8];
                if (i == 0) begin
                    model_ptr = d[3:0];
                end else begin
                    wr_q.push_back({model_ptr, d});
                    model_mem[model_ptr] = d;
                    model_ptr++;
                end
                send_byte(d, a);
                check($sformatf("v%0d_wr%0d_ack", idx, i), {31'd0, a}, 32'd0);
            end
            if (v.nrd > 0) begin
                if (v.nwr > 0) begin
                    start_cond();
                    send_byte({v.addr, 1'b1}, a);
                    check($sformatf("v%0d_rd_addr_ack", idx), {31'd0, a}, 32'd0);
                end
                for (int i = 0; i < v.nrd; i++) begin
                    rd_q.push_back(model_mem[model_ptr]);
                    model_ptr++;
                    recv_byte(i == v.nrd - 1, d);
                    e = rd_q.pop_front();
                    check($sformatf("v%0d_rd%0d_data", idx, i), {24'd0, d}, {24'd0, e});
                end
            end
        end
        stop_cond();
        check($sformatf("v%0d_busy_after_stop", idx), {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       a;
        logic [7:0] d;
        int         n;
        vec_t       tail;

        vecs[0]  = '{7'h22, 3, 24'h5AA503, 0, 1'b1};
        vecs[1]  = '{7'h23, 2, 24'h007703, 0, 1'b0};
        vecs[2]  = '{7'h22, 1, 24'h000003, 2, 1'b1};
        vecs[3]  = '{7'h22, 3, 24'h22110F, 0, 1'b1};
        vecs[4]  = '{7'h22, 1, 24'h00000F, 2, 1'b1};
        vecs[5]  = '{7'h22, 2, 24'h0066F3, 0, 1'b1};
        vecs[6]  = '{7'h22, 1, 24'h000003, 2, 1'b1};
        vecs[7]  = '{7'h22, 2, 24'h003C05, 0, 1'b1};
        vecs[8]  = '{7'h22, 1, 24'h000005, 0, 1'b1};
        vecs[9]  = '{7'h22, 0, 24'h000000, 1, 1'b1};
        vecs[10] = '{7'h21, 0, 24'h000000, 1, 1'b0};

        rst = 1'b1; scl = 1'b1; m_low = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_sda_drive_low", {31'd0, dut_low}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_sda_released", {31'd0, dut_low}, 32'd0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // STOP four bits into a data byte: the partial byte must vanish.
        start_cond();
        send_byte(8'h44, a);
        check("mid_stop_addr_ack", {31'd0, a}, 32'd0);
        send_byte(8'h08, a);
        check("mid_stop_ptr_ack", {31'd0, a}, 32'd0);
        model_ptr = 4'd8;
        d = 8'hB7;
        for (int i = 7; i >= 4; i--) write_bit(d[i]);
        stop_cond();
        check("mid_stop_busy", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clk);
        tail = '{7'h22, 2, 24'h009E08, 0, 1'b1};
        run_vec(tail, 11);

        // Reset asserted while the target holds the address ACK low.
        start_cond();
        d = 8'h44;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        m_low = 1'b0;
        n = 0;
        while (!dut_low && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ack_driven_before_rst", {31'd0, dut_low}, 32'd1);
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_sda_released", {31'd0, dut_low}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_wr_addr", {28'd0, wr_addr}, 32'd0);
        check("rst_mid_wr_data", {24'd0, wr_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_ptr = 4'd0;
        stop_cond();
        tail = '{7'h22, 0, 24'h000000, 1, 1'b1};
        run_vec(tail, 12);

        repeat (10) @(negedge clk);
        check("wr_q_drained", wr_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
